// File: rtl/activation_pkg.sv
// Shared types and helpers for the activation arbiter.
package activation_pkg;

    // Transaction phases; the completion step returns straight to IDLE.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARG  = 3'd1,
        RES  = 3'd2,
        ERR  = 3'd3,
        FBK  = 3'd4
    } state_t;

    // Index width that stays at least one bit wide for tiny lane counts.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/activation_arbiter_if.sv
// Lane-side and unit-side channels of the activation arbiter.
// slave: arbiter view; master: view of the lanes plus the activation unit.
interface activation_arbiter_if
    import activation_pkg::*;
#(
    parameter int N    = 4,
    parameter int ARGW = 16,
    parameter int RESW = 8,
    parameter int ERRW = 16,
    parameter int FBKW = 16
);
    localparam int GW = idx_width(N);

    logic [N-1:0]      train;
    logic [N*ARGW-1:0] arg_data;
    logic [N-1:0]      arg_valid;
    logic [N-1:0]      arg_ready;
    logic [RESW-1:0]   res_data;
    logic [N-1:0]      res_valid;
    logic [N-1:0]      res_ready;
    logic [N*ERRW-1:0] err_data;
    logic [N-1:0]      err_valid;
    logic [N-1:0]      err_ready;
    logic [FBKW-1:0]   fbk_data;
    logic [N-1:0]      fbk_valid;
    logic [N-1:0]      fbk_ready;

    logic [ARGW-1:0]   act_arg_data;
    logic              act_arg_valid;
    logic              act_arg_ready;
    logic [RESW-1:0]   act_res_data;
    logic              act_res_valid;
    logic              act_res_ready;
    logic [ERRW-1:0]   act_err_data;
    logic              act_err_valid;
    logic              act_err_ready;
    logic [FBKW-1:0]   act_fbk_data;
    logic              act_fbk_valid;
    logic              act_fbk_ready;
    logic              act_en;

    logic [GW-1:0]     grant;
    logic              busy;

    modport slave (
        input  train, arg_data, arg_valid, res_ready, err_data, err_valid, fbk_ready,
        output arg_ready, res_data, res_valid, err_ready, fbk_data, fbk_valid,
        output act_arg_data, act_arg_valid, act_res_ready, act_err_data, act_err_valid,
        output act_fbk_ready, act_en, grant, busy,
        input  act_arg_ready, act_res_data, act_res_valid, act_err_ready,
        input  act_fbk_data, act_fbk_valid
    );

    modport master (
        output train, arg_data, arg_valid, res_ready, err_data, err_valid, fbk_ready,
        input  arg_ready, res_data, res_valid, err_ready, fbk_data, fbk_valid,
        input  act_arg_data, act_arg_valid, act_res_ready, act_err_data, act_err_valid,
        input  act_fbk_ready, act_en, grant, busy,
        output act_arg_ready, act_res_data, act_res_valid, act_err_ready,
        output act_fbk_data, act_fbk_valid
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after start_i, wrapping.
module rr_pick #(
    parameter int N = 4,
    parameter int W = activation_pkg::idx_width(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    int unsigned j;

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        j       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (32'(start_i) + i) % N;
            if (!found_o && req_i[j]) begin
                idx_o   = W'(j);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/activation_arbiter.sv
// Shares one activation unit among N lanes, one transaction at a time.
// Optional macro ACTIVATION_ARBITER_ROUND_ROBIN_EN: round-robin grant;
// otherwise fixed priority (lowest lane index wins, no pointer register).
module activation_arbiter
    import activation_pkg::*;
#(
    parameter int N    = 4,
    parameter int ARGW = 16,
    parameter int RESW = 8,
    parameter int ERRW = 16,
    parameter int FBKW = 16
) (
    input  logic clk,
    input  logic rst_n,
    activation_arbiter_if.slave bus
);

    localparam int GW = idx_width(N);

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic          act_en_q, act_en_d;
    logic [GW-1:0] pick_idx;
    logic          pick_found;
    logic          done;

`ifdef ACTIVATION_ARBITER_ROUND_ROBIN_EN
    logic [GW-1:0] ptr_q, ptr_d;

    rr_pick #(.N(N), .W(GW)) u_pick (
        .req_i   (bus.arg_valid),
        .start_i (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Pointer moves just past the lane that finished.
    always_comb begin
        ptr_d = ptr_q;
        if (done) begin
            ptr_d = (grant_q == GW'(N - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: scanning downwards leaves the lowest requester selected.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int unsigned i = N; i > 0; i--) begin
            if (bus.arg_valid[i-1]) begin
                pick_idx   = GW'(i - 1);
                pick_found = 1'b1;
            end
        end
    end
`endif

    // Next-state logic: grant and training mode are latched on leaving IDLE.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        act_en_d = act_en_q;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d  = pick_idx;
                    act_en_d = bus.train[pick_idx];
                    state_d  = ARG;
                end
            end
            ARG: begin
                if (bus.arg_valid[grant_q] && bus.act_arg_ready) begin
                    state_d = RES;
                end
            end
            RES: begin
                if (bus.act_res_valid && bus.res_ready[grant_q]) begin
                    if (act_en_q) begin
                        state_d = ERR;
                    end else begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end
                end
            end
            ERR: begin
                if (bus.err_valid[grant_q] && bus.act_err_ready) begin
                    state_d = FBK;
                end
            end
            FBK: begin
                if (bus.act_fbk_valid && bus.fbk_ready[grant_q]) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (done) begin
            act_en_d = 1'b0;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            act_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            act_en_q <= act_en_d;
        end
    end

    // Channel steering from the registered grant; only the active phase opens.
    always_comb begin
        bus.arg_ready     = '0;
        bus.res_valid     = '0;
        bus.err_ready     = '0;
        bus.fbk_valid     = '0;
        bus.act_arg_valid = 1'b0;
        bus.act_res_ready = 1'b0;
        bus.act_err_valid = 1'b0;
        bus.act_fbk_ready = 1'b0;
        bus.act_arg_data  = bus.arg_data[grant_q*ARGW +: ARGW];
        bus.act_err_data  = bus.err_data[grant_q*ERRW +: ERRW];
        bus.res_data      = bus.act_res_data;
        bus.fbk_data      = bus.act_fbk_data;
        unique case (state_q)
            ARG: begin
                bus.act_arg_valid      = bus.arg_valid[grant_q];
                bus.arg_ready[grant_q] = bus.act_arg_ready;
            end
            RES: begin
                bus.res_valid[grant_q] = bus.act_res_valid;
                bus.act_res_ready      = bus.res_ready[grant_q];
            end
            ERR: begin
                bus.act_err_valid      = bus.err_valid[grant_q];
                bus.err_ready[grant_q] = bus.act_err_ready;
            end
            FBK: begin
                bus.fbk_valid[grant_q] = bus.act_fbk_valid;
                bus.act_fbk_ready      = bus.fbk_ready[grant_q];
            end
            default: ;
        endcase
    end

    assign bus.act_en = act_en_q;
    assign bus.grant  = grant_q;
    assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_activation_arbiter.sv
// Directed self-checking bench for activation_arbiter (N=4); the bench plays
// both the lanes and the activation unit.
module tb_activation_arbiter;

    localparam int N    = 4;
    localparam int ARGW = 16;
    localparam int RESW = 8;
    localparam int ERRW = 16;
    localparam int FBKW = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    activation_arbiter_if #(.N(N), .ARGW(ARGW), .RESW(RESW), .ERRW(ERRW), .FBKW(FBKW)) bus ();

    activation_arbiter #(.N(N), .ARGW(ARGW), .RESW(RESW), .ERRW(ERRW), .FBKW(FBKW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.train         = '0;
        bus.arg_data      = '0;
        bus.arg_valid     = '0;
        bus.res_ready     = '0;
        bus.err_data      = '0;
        bus.err_valid     = '0;
        bus.fbk_ready     = '0;
        bus.act_arg_ready = 1'b0;
        bus.act_res_data  = '0;
        bus.act_res_valid = 1'b0;
        bus.act_err_ready = 1'b0;
        bus.act_fbk_data  = '0;
        bus.act_fbk_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Watchdog: the whole run is a few hundred cycles.
    initial begin
        repeat (1000000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int unsigned exp_seq [4];
    int          hs_cyc [4];
    int          hs_n;

    initial begin
`ifdef ACTIVATION_ARBITER_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 2, 3};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        clear_inputs();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("rst_busy",      bus.busy, 0);
        check("rst_grant",     bus.grant, 0);
        check("rst_act_en",    bus.act_en, 0);
        check("rst_arg_ready", bus.arg_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_act_arg_v", bus.act_arg_valid, 0);
        tick();
        rst_n = 1'b1;

        // Lane 2 forward, arg 0 -> result 0xFF.
        bus.arg_valid[2]         = 1'b1;
        bus.arg_data[2*ARGW +: ARGW] = 16'h0000;
        bus.act_arg_ready        = 1'b1;
        bus.act_res_valid        = 1'b1;
        bus.act_res_data         = 8'hFF;
        bus.res_ready            = 4'b0100;
        @(negedge clk);
        check("t1_idle_no_hs",   bus.arg_ready, 0);
        tick();
        @(negedge clk);
        check("t1_grant",        bus.grant, 2);
        check("t1_act_en",       bus.act_en, 0);
        check("t1_arg_ready",    bus.arg_ready, 4'b0100);
        check("t1_act_arg_data", bus.act_arg_data, 16'h0000);
        tick();
        bus.arg_valid = '0;
        @(negedge clk);
        check("t1_res_valid",    bus.res_valid, 4'b0100);
        check("t1_res_data",     bus.res_data, 8'hFF);
        check("t1_act_res_rdy",  bus.act_res_ready, 1);
        tick();
        @(negedge clk);
        check("t1_busy_done",    bus.busy, 0);

        // Lane 1 training transaction.
        bus.train                    = 4'b0010;
        bus.arg_valid                = 4'b0010;
        bus.arg_data[1*ARGW +: ARGW] = 16'hFFFF;
        bus.err_valid                = 4'b0010;
        bus.err_data[1*ERRW +: ERRW] = 16'hFFFF;
        bus.res_ready                = 4'b0010;
        bus.fbk_ready                = 4'b0010;
        bus.act_res_data             = 8'h00;
        bus.act_err_ready            = 1'b1;
        bus.act_fbk_valid            = 1'b1;
        bus.act_fbk_data             = 16'hFFFF;
        tick();
        @(negedge clk);
        check("t2_grant",        bus.grant, 1);
        check("t2_act_en_arg",   bus.act_en, 1);
        check("t2_arg_ready",    bus.arg_ready, 4'b0010);
        check("t2_act_arg_data", bus.act_arg_data, 16'hFFFF);
        tick();
        bus.arg_valid = '0;
        bus.train     = '0;
        @(negedge clk);
        check("t2_res_valid",    bus.res_valid, 4'b0010);
        check("t2_res_data",     bus.res_data, 8'h00);
        check("t2_act_en_res",   bus.act_en, 1);
        tick();
        @(negedge clk);
        check("t2_act_err_v",    bus.act_err_valid, 1);
        check("t2_err_ready",    bus.err_ready, 4'b0010);
        check("t2_act_err_data", bus.act_err_data, 16'hFFFF);
        check("t2_res_v_off",    bus.res_valid, 0);
        tick();
        bus.err_valid = '0;
        @(negedge clk);
        check("t2_fbk_valid",    bus.fbk_valid, 4'b0010);
        check("t2_fbk_data",     bus.fbk_data, 16'hFFFF);
        check("t2_act_en_fbk",   bus.act_en, 1);
        tick();
        @(negedge clk);
        check("t2_busy_done",    bus.busy, 0);
        check("t2_act_en_done",  bus.act_en, 0);
        check("t2_fbk_v_off",    bus.fbk_valid, 0);

        // All four lanes request; lane 0 keeps re-requesting.
        do_reset();
        bus.arg_valid     = 4'b1111;
        bus.res_ready     = 4'b1111;
        bus.act_arg_ready = 1'b1;
        bus.act_res_valid = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check($sformatf("t3_grant%0d", k), bus.grant, exp_seq[k]);
            check($sformatf("t3_single%0d", k), $countones(bus.arg_ready), 1);
            tick();
            if (exp_seq[k] != 0) bus.arg_valid[exp_seq[k]] = 1'b0;
            tick();
        end
        bus.arg_valid = '0;

        // Unit stalls the result; a late lane 3 request must wait.
        bus.arg_valid[0]  = 1'b1;
        bus.act_res_valid = 1'b0;
        tick();
        tick();
        bus.arg_valid[0] = 1'b0;
        bus.arg_valid[3] = 1'b1;
        for (int unsigned c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("t4_grant%0d", c), bus.grant, 0);
            check($sformatf("t4_arg_rdy%0d", c), bus.arg_ready, 0);
            check($sformatf("t4_res_v%0d", c), bus.res_valid, 0);
            tick();
        end
        bus.act_res_valid = 1'b1;
        @(negedge clk);
        check("t4_res_valid",  bus.res_valid, 4'b0001);
        tick();
        tick();
        @(negedge clk);
        check("t4_late_grant", bus.grant, 3);
        check("t4_late_rdy",   bus.arg_ready, 4'b1000);
        tick();
        bus.arg_valid = '0;
        tick();

        // Reset while lane 1 sits in the feedback phase.
        bus.train         = 4'b0010;
        bus.arg_valid     = 4'b0010;
        bus.err_valid     = 4'b0010;
        bus.act_err_ready = 1'b1;
        bus.act_fbk_valid = 1'b0;
        bus.fbk_ready     = 4'b1111;
        tick();
        tick();
        bus.arg_valid = '0;
        tick();
        tick();
        bus.err_valid = '0;
        @(negedge clk);
        check("t5_fbk_grant",   bus.grant, 1);
        check("t5_fbk_ready",   bus.act_fbk_ready, 1);
        check("t5_fbk_act_en",  bus.act_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy",    bus.busy, 0);
        check("t5_rst_grant",   bus.grant, 0);
        check("t5_rst_act_en",  bus.act_en, 0);
        check("t5_rst_fbk_rdy", bus.act_fbk_ready, 0);
        tick();
        rst_n                        = 1'b1;
        bus.train                    = '0;
        bus.arg_valid                = 4'b0100;
        bus.arg_data[2*ARGW +: ARGW] = 16'h0000;
        bus.act_res_data             = 8'hFF;
        tick();
        @(negedge clk);
        check("t5_after_grant", bus.grant, 2);
        tick();
        bus.arg_valid = '0;
        @(negedge clk);
        check("t5_after_res_v", bus.res_valid, 4'b0100);
        check("t5_after_res_d", bus.res_data, 8'hFF);
        tick();
        @(negedge clk);
        check("t5_after_idle",  bus.busy, 0);

        // Back-to-back lane 0 forwards: one handshake every three cycles.
        bus.arg_valid = 4'b0001;
        bus.res_ready = 4'b1111;
        hs_cyc        = '{-100, -100, -100, -100};
        hs_n          = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.act_arg_valid && bus.act_arg_ready && hs_n < 4) begin
                hs_cyc[hs_n] = c;
                hs_n++;
            end
        end
        bus.arg_valid = '0;
        check("t6_gap1", 32'(hs_cyc[1] - hs_cyc[0]), 3);
        check("t6_gap2", 32'(hs_cyc[2] - hs_cyc[1]), 3);
        check("t6_gap3", 32'(hs_cyc[3] - hs_cyc[2]), 3);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
